// File: rtl/syncnt_sweep_ctrl.sv
// syncnt_sweep_ctrl
// Sequences an up/down counter (no load input) so its count first seeks to lo,
// then sweeps lo->hi->lo for a programmed number of passes, then pulses done.
// Ports:
//   clk, nrst        clock (rising) / synchronous active-low reset, shared with the counter
//   start, abort     sweep request (IDLE only) / immediate stop (any state)
//   lo, hi, reps     bounds and pass count, latched on an accepted start; reps=0 runs forever
//   cnt_q            counter value
//   cnt_en, cnt_down counter controls, combinational from state and cnt_q
//   busy, done, err  registered status; done/err are single-cycle pulses
//   pass_cnt         completed passes (registered)
module syncnt_sweep_ctrl #(
  parameter int W  = 3,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic [RW-1:0] reps,
  input  logic [W-1:0]  cnt_q,
  output logic          cnt_en,
  output logic          cnt_down,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [RW-1:0] pass_cnt
);

  typedef enum logic [1:0] {IDLE, SEEK, UP, DOWN} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  lo_r, hi_r;
  logic [RW-1:0] reps_r;
  logic          latch, pass_inc, done_nxt, err_nxt;
  logic [RW-1:0] pass_p1;
  logic          out_rng;

  assign pass_p1 = pass_cnt + RW'(1);
  // Only reachable by a counter fault: legitimate moves never leave the bounds.
  assign out_rng = (cnt_q < lo_r) || (cnt_q > hi_r);

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_down  = 1'b0;
    latch     = 1'b0;
    pass_inc  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (lo <= hi) begin
            latch     = 1'b1;
            state_nxt = SEEK;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SEEK: begin
        if (abort) state_nxt = IDLE;
        else if (cnt_q != lo_r) begin
          cnt_en   = 1'b1;
          cnt_down = (cnt_q > lo_r);
        end else state_nxt = UP;
      end
      UP: begin
        if (abort) state_nxt = IDLE;
        else if (out_rng) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (cnt_q < hi_r) cnt_en = 1'b1;
        else state_nxt = DOWN;
      end
      DOWN: begin
        cnt_down = 1'b1;
        // abort wins over a pass completing in the same cycle
        if (abort) state_nxt = IDLE;
        else if (out_rng) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (cnt_q > lo_r) cnt_en = 1'b1;
        else begin
          pass_inc = 1'b1;
          if (reps_r != '0 && pass_p1 == reps_r) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else state_nxt = UP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pass_cnt <= '0;
      lo_r     <= '0;
      hi_r     <= '0;
      reps_r   <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= done_nxt;
      err   <= err_nxt;
      if (latch) begin
        lo_r     <= lo;
        hi_r     <= hi;
        reps_r   <= reps;
        pass_cnt <= '0;
      end else if (pass_inc) begin
        pass_cnt <= pass_p1;
      end
    end
  end

endmodule

// File: tb/tb_syncnt_sweep_ctrl.sv
// Directed bench for syncnt_sweep_ctrl with a behavioural up/down counter
// closing the loop. Inputs are driven and outputs sampled 1ns after each
// rising edge; "cycle n" is the interval following the n-th edge after start.
module tb_syncnt_sweep_ctrl;
  localparam int W  = 3;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          nrst, start, abort;
  logic [W-1:0]  lo, hi;
  logic [RW-1:0] reps;
  logic [W-1:0]  cq;
  logic          cnt_en, cnt_down, busy, done, err;
  logic [RW-1:0] pass_cnt;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  // counter under control: shares clk/nrst, clears to 0 on reset
  always @(posedge clk) begin
    if (!nrst)       cq <= '0;
    else if (cnt_en) cq <= cnt_down ? cq - 1'b1 : cq + 1'b1;
  end

  syncnt_sweep_ctrl #(.W(W), .RW(RW)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .reps(reps), .cnt_q(cq),
    .cnt_en(cnt_en), .cnt_down(cnt_down), .busy(busy), .done(done),
    .err(err), .pass_cnt(pass_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // start a sweep in cycle 0, return positioned in cycle 1
  task automatic go(input int l, input int h, input int r);
    lo = W'(l); hi = W'(h); reps = RW'(r);
    start = 1'b1;
    #1;
    chk("go_en0", cnt_en, 0);
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp1 [11];
    bit saw_done;
    exp1 = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd4, 3'd3, 3'd2};
    nrst = 1'b0; start = 1'b0; abort = 1'b0;
    lo = '0; hi = '0; reps = '0;
    #1;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_cq", cq, 0);
    chk("rst_en", cnt_en, 0);
    nrst = 1'b1;
    tick();

    // 1: lo=2 hi=5 reps=1 from 0
    go(2, 5, 1);
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) tick();
      chk($sformatf("t1_cq_c%0d", c), cq, exp1[c-1]);
      chk($sformatf("t1_busy_c%0d", c), busy, 1);
      chk($sformatf("t1_done_c%0d", c), done, 0);
    end
    tick();
    chk("t1_done", done, 1);
    chk("t1_pass", pass_cnt, 1);
    chk("t1_busy_end", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // park count at 7: sweep to hi=7 and abort at the turning stall
    go(2, 7, 0);
    repeat (6) tick();
    chk("t2_pre_cq7", cq, 7);
    chk("t2_pre_stall", cnt_en, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t2_pre_idle", busy, 0);

    // 2: lo=1 hi=3 reps=2 from 7
    go(1, 3, 2);
    chk("t2_seek_down", cnt_down, 1);
    chk("t2_seek_en", cnt_en, 1);
    repeat (6) tick();
    chk("t2_seek_lo", cq, 1);
    chk("t2_seek_stall", cnt_en, 0);
    repeat (7) tick();
    chk("t2_pass1", pass_cnt, 1);
    chk("t2_busy_mid", busy, 1);
    chk("t2_done_mid", done, 0);
    repeat (5) tick();
    chk("t2_last_stall", cnt_en, 0);
    chk("t2_done_early", done, 0);
    tick();
    chk("t2_done", done, 1);
    chk("t2_pass2", pass_cnt, 2);
    chk("t2_busy_end", busy, 0);
    chk("t2_cq", cq, 1);

    // 3: lo=hi=4 reps=3; seek 1->4 then six stall cycles
    go(4, 4, 3);
    repeat (3) tick();
    chk("t3_seek_cq4", cq, 4);
    for (int c = 5; c <= 10; c++) begin
      tick();
      chk($sformatf("t3_en0_c%0d", c), cnt_en, 0);
      chk($sformatf("t3_done0_c%0d", c), done, 0);
    end
    tick();
    chk("t3_done", done, 1);
    chk("t3_pass3", pass_cnt, 3);
    chk("t3_cq", cq, 4);

    // 4: bad bounds
    go(5, 2, 1);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_en", cnt_en, 0);
    tick();
    chk("t4_err_pulse", err, 0);
    chk("t4_cq", cq, 4);

    // 5: reps=0 lo=0 hi=7, abort mid-UP at 4
    go(0, 7, 0);
    chk("t5_cq", cq, 4);
    repeat (4) tick();
    chk("t5_seek_lo", cq, 0);
    repeat (5) tick();
    chk("t5_up_cq4", cq, 4);
    chk("t5_up_en", cnt_en, 1);
    chk("t5_up_dir", cnt_down, 0);
    abort = 1'b1;
    #1;
    chk("t5_abort_en0", cnt_en, 0);
    tick();
    abort = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_nodone", done, 0);
    tick();
    chk("t5_hold_cq", cq, 4);

    // 5b: reps=0 lo=hi=4: pass_cnt wraps, no done; abort holds pass_cnt
    go(4, 4, 0);
    saw_done = 1'b0;
    for (int c = 2; c <= 36; c++) begin
      tick();
      if (done) saw_done = 1'b1;
      if (c == 32) chk("t5b_pass15", pass_cnt, 15);
      if (c == 34) chk("t5b_wrap0", pass_cnt, 0);
    end
    chk("t5b_pass1", pass_cnt, 1);
    chk("t5b_nodone", saw_done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5b_idle", busy, 0);
    chk("t5b_hold_pass", pass_cnt, 1);
    chk("t5b_abort_nodone", done, 0);

    // 6: reset during DOWN of second pass
    go(0, 2, 0);
    repeat (14) tick();
    chk("t6_pass1", pass_cnt, 1);
    chk("t6_down", cnt_down, 1);
    chk("t6_cq", cq, 2);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("t6_busy", busy, 0);
    chk("t6_pass0", pass_cnt, 0);
    chk("t6_cq0", cq, 0);
    lo = 3'd1; hi = 3'd3; reps = 4'd1;
    start = 1'b1; abort = 1'b1;
    #1;
    chk("t6_sa_en", cnt_en, 0);
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t6_sa_busy", busy, 0);
    chk("t6_sa_err", err, 0);
    tick();
    chk("t6_sa_busy2", busy, 0);
    chk("t6_sa_cq", cq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
